uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_frame.sv | 140 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line parity modes, transmitter FSM states and
// baud-divider sizing helpers used by the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Truncating division: a non-integer ratio leaves the line slightly fast.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: one-clock tick every DIV clocks while enabled, restarted
// by clear. pre_tick fires the clock before tick so callers can register
// events that must coincide with the last clock of a bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] cnt;

    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick     = enable && !clear && (cnt == CW'(DIV - 1));
    assign pre_tick = enable && !clear && (cnt == CW'(DIV - 2));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready transfer, framed as start bit,
// LSB-first data, optional parity and one or two stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W        = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 2) begin : g_bad_div
        $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_frame: DATA_BITS must be within 5..9");
    end

    tx_state_t            state, state_d;
    parity_mode_t         mode;
    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     bit_idx;
    logic                 par_en_q, par_bit_q, two_stop_q, stop_idx;
    logic                 tick, pre_tick;
    logic                 start_xfer, last_data, last_stop;
    logic                 tx_d, busy_d, done_d;

    assign mode       = parity_mode_t'(parity_mode);
    assign tx_ready   = (state == ST_IDLE);
    assign start_xfer = tx_ready && tx_valid;
    assign last_data  = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop  = (stop_idx == two_stop_q);

    uart_baud_tick #(
        .DIV(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_xfer),
        .enable  (state != ST_IDLE),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (tx_valid) state_d = ST_START;
            ST_START:  if (tick) state_d = ST_DATA;
            ST_DATA:   if (tick && last_data) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick && last_stop) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes
    // on the same edge as the state it belongs to.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = (state == ST_DATA && tick) ? shift_q[1] : shift_q[0];
            ST_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state == ST_STOP) && last_stop && pre_tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx   <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            tx   <= tx_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (start_xfer) begin
            shift_q    <= tx_data;
            par_en_q   <= (mode == PAR_EVEN) || (mode == PAR_ODD);
            par_bit_q  <= (mode == PAR_ODD) ? ~^tx_data : ^tx_data;
            two_stop_q <= two_stop;
        end else if (state == ST_DATA && tick) begin
            shift_q <= shift_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            if (state != ST_DATA) begin
                bit_idx <= '0;
            end else if (tick) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (state != ST_STOP) begin
                stop_idx <= 1'b0;
            end else if (tick) begin
                stop_idx <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames, back-to-back,
// mid-frame reset and a randomized scoreboard against a bit-list frame model.
module tb_uart_tx_frame;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid8 = 1'b0, two8 = 1'b0, ready8, tx8, busy8, done8;
    logic [7:0] data8 = '0;
    logic [1:0] mode8 = '0;
    logic       valid5 = 1'b0, two5 = 1'b0, ready5, tx5, busy5, done5;
    logic [4:0] data5 = '0;
    logic [1:0] mode5 = '0;

    logic sel = 1'b0;
    logic obs_tx, obs_busy, obs_done, obs_ready;
    int   passed = 0;
    int   total = 0;
    bit   exp_bits[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid8), .tx_ready(ready8),
        .tx_data(data8), .parity_mode(mode8), .two_stop(two8),
        .tx(tx8), .busy(busy8), .done(done8)
    );

    uart_tx_frame #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid5), .tx_ready(ready5),
        .tx_data(data5), .parity_mode(mode5), .two_stop(two5),
        .tx(tx5), .busy(busy5), .done(done5)
    );

    assign obs_tx    = sel ? tx5    : tx8;
    assign obs_busy  = sel ? busy5  : busy8;
    assign obs_done  = sel ? done5  : done8;
    assign obs_ready = sel ? ready5 : ready8;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Frame model: list of line levels, one entry per bit time.
    task automatic build_frame(input int nbits, input logic [8:0] data,
                               input logic [1:0] mode, input logic two);
        int ones;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            exp_bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (mode == 2'b01) exp_bits.push_back(bit'(ones % 2));
        if (mode == 2'b10) exp_bits.push_back(bit'(1 - ones % 2));
        exp_bits.push_back(1'b1);
        if (two) exp_bits.push_back(1'b1);
    endtask

    task automatic drive(input logic s, input logic v, input logic [8:0] d,
                         input logic [1:0] m, input logic t);
        if (s) begin
            valid5 = v; data5 = d[4:0]; mode5 = m; two5 = t;
        end else begin
            valid8 = v; data8 = d[7:0]; mode8 = m; two8 = t;
        end
    endtask

    // Called at a negedge; returns at the negedge of the idle clock after the frame.
    task automatic send(input logic s, input logic [8:0] data, input logic [1:0] mode,
                        input logic two, input logic hold, input logic [8:0] mid_data);
        int n, waited, done_at, bad_tx, bad_busy, bad_done, b;
        sel = s;
        build_frame(s ? 5 : 8, data, mode, two);
        n = exp_bits.size() * CPB;
        drive(s, 1'b1, data, mode, two);
        waited = 0;
        while (obs_ready !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", obs_ready, 1);
        @(posedge clk);
        #1;
        drive(s, hold, mid_data, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        done_at = 0; bad_tx = 0; bad_busy = 0; bad_done = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            b = (c - 1) / CPB;
            if (obs_tx !== exp_bits[b]) bad_tx++;
            if ((c - 1) % CPB == CPB / 2)
                check($sformatf("bit%0d", b), obs_tx, exp_bits[b]);
            if (obs_busy !== 1'b1 || obs_ready !== 1'b0) bad_busy++;
            if (obs_done === 1'b1 && done_at == 0) done_at = c;
            if (obs_done !== (c == n)) bad_done++;
        end
        check("tx_cycle_errs", bad_tx, 0);
        check("busy_ready_errs", bad_busy, 0);
        check("done_at", done_at, n);
        check("done_errs", bad_done, 0);
        @(negedge clk);
        check("idle_after", {obs_tx, obs_busy, obs_ready, obs_done}, 4'b1010);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s, s_next, hold;
        int   flips, dones;

        repeat (3) @(negedge clk);
        check("rst_dut8", {tx8, ready8, busy8, done8}, 4'b1100);
        check("rst_dut5", {tx5, ready5, busy5, done5}, 4'b1100);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_dut8", {tx8, ready8, busy8, done8}, 4'b1100);

        // 8-O-1 with 0xA5, then 8-E-2 with 0x07, then 5-N-1 with 0x1F.
        send(1'b0, 9'h0A5, 2'b10, 1'b0, 1'b0, 9'h05A);
        send(1'b0, 9'h007, 2'b01, 1'b1, 1'b0, 9'h0F8);
        send(1'b1, 9'h01F, 2'b00, 1'b0, 1'b0, 9'h000);

        // Back-to-back with tx_valid held: exactly one idle clock between frames.
        send(1'b0, 9'h000, 2'b10, 1'b0, 1'b1, 9'h0FF);
        send(1'b0, 9'h0FF, 2'b01, 1'b0, 1'b1, 9'h000);
        send(1'b0, 9'h03C, 2'b00, 1'b1, 1'b0, 9'h0C3);

        // Reset during data bit 3 (cycles 41..50 after transfer).
        sel = 1'b0;
        drive(1'b0, 1'b1, 9'h0A5, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 9'h0A5, 2'b10, 1'b0);
        repeat (45) @(negedge clk);
        check("bit3_before_rst", tx8, 0);
        rst_n = 1'b0;
        #1;
        check("rst_midframe", {tx8, busy8, ready8, done8}, 4'b1010);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        flips = 0;
        repeat (100) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
            if (tx8 !== 1'b1 || busy8 !== 1'b0) flips++;
        end
        check("no_done_after_rst", dones, 0);
        check("idle_after_rst", flips, 0);
        send(1'b0, 9'h0A5, 2'b10, 1'b0, 1'b0, 9'h000);

        // Randomized scoreboard across both data widths.
        s = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 200; i++) begin
            s_next = ($urandom_range(0, 3) == 0);
            hold = (i != 199) && (s_next == s) && ($urandom_range(0, 1) == 1);
            send(s, 9'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 hold, 9'($urandom));
            s = s_next;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
